// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_e;

  // Number of select lines for a given address width.
  function automatic int out_w(input int in_w);
    return 1 << in_w;
  endfunction

  // Behavioural one-hot reference; addresses outside the width give all-zero.
  function automatic logic [255:0] onehot(input logic [7:0] addr, input int width);
    logic [255:0] r;
    r = '0;
    if (int'(addr) < width) r[addr] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_n_tree.sv
// Combinational binary -> one-hot decoder built from 2-to-4 predecode stages with an enable.
module decoder_n_tree #(
  parameter int IN_W  = 5,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             en,
  input  logic [IN_W-1:0]  addr,
  output logic [OUT_W-1:0] out
);

  localparam int NS = (IN_W + 1) / 2;

  // lvl[s] holds every line gated by en and the first s address digits.
  logic [NS:0][OUT_W-1:0] lvl;

  assign lvl[0] = {OUT_W{en}};

  for (genvar s = 0; s < NS; s++) begin : g_stg
    if (2*s + 2 <= IN_W) begin : g_quad
      logic [3:0] pre;
      assign pre = 4'b0001 << addr[2*s +: 2];
      for (genvar i = 0; i < OUT_W; i++) begin : g_ln
        assign lvl[s+1][i] = lvl[s][i] & pre[(i >> (2*s)) % 4];
      end
    end else begin : g_pair
      // Odd address width: the last stage only decodes a single bit.
      for (genvar i = 0; i < OUT_W; i++) begin : g_ln
        assign lvl[s+1][i] = lvl[s][i] & (addr[2*s] == ((i >> (2*s)) % 2 == 1));
      end
    end
  end

  assign out = lvl[NS];

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with valid/ready input, global enable and auto-scan mode.
// Build option DECODER_SCAN_BLANK_EN inserts one blank cycle before each new scan line.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int IN_W    = 5,
  parameter int DWELL_W = 8,
  localparam int OUT_W  = 1 << IN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic [IN_W-1:0]    cur_addr,
  output logic               wrap
);

  state_e               state_q, state_d;
  logic [IN_W-1:0]      cur_addr_q, cur_addr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 wrap_q, wrap_d;
`ifdef DECODER_SCAN_BLANK_EN
  logic                 blank_q, blank_d;
`endif

  assign in_ready = en & ~mode & (state_q != SCAN);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
    out_valid_d = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
    blank_d     = blank_q;
`endif
    // en low leaves all state untouched and only blanks the outputs.
    if (en) begin
      case (state_q)
        IDLE, HOLD: begin
          out_valid_d = (state_q == HOLD);
          if (mode) begin
            state_d     = SCAN;
            cur_addr_d  = '0;
            cnt_d       = dwell;
            out_valid_d = 1'b1;
`ifdef DECODER_SCAN_BLANK_EN
            blank_d     = 1'b0;
`endif
          end else if (in_valid) begin
            state_d     = HOLD;
            cur_addr_d  = in_addr;
            out_valid_d = 1'b1;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_d = IDLE;
`ifdef DECODER_SCAN_BLANK_EN
            blank_d = 1'b0;
`endif
          end else begin
            out_valid_d = 1'b1;
`ifdef DECODER_SCAN_BLANK_EN
            if (blank_q) begin
              blank_d    = 1'b0;
              cur_addr_d = cur_addr_q + IN_W'(1);
              cnt_d      = dwell;
              wrap_d     = (cur_addr_q == '1);
            end else if (cnt_q == '0) begin
              blank_d     = 1'b1;
              out_valid_d = 1'b0;
            end else begin
              cnt_d = cnt_q - DWELL_W'(1);
            end
`else
            if (cnt_q == '0) begin
              cur_addr_d = cur_addr_q + IN_W'(1);
              cnt_d      = dwell;
              wrap_d     = (cur_addr_q == '1);
            end else begin
              cnt_d = cnt_q - DWELL_W'(1);
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Decoder enable doubles as the blanking gate, so out is zero whenever invalid.
  decoder_n_tree #(.IN_W(IN_W)) u_tree (
    .en   (out_valid_d),
    .addr (cur_addr_d),
    .out  (out_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

`ifdef DECODER_SCAN_BLANK_EN
  always_ff @(posedge clk) begin
    if (rst) blank_q <= 1'b0;
    else     blank_q <= blank_d;
  end
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cur_addr  = cur_addr_q;
  assign wrap      = wrap_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_q));
  a_valid:  assert property (@(posedge clk) disable iff (rst) out_valid_q == (|out_q));
  a_ready:  assert property (@(posedge clk) disable iff (rst) (state_q == SCAN) |-> !in_ready);

endmodule
